script_executor: RTL and testbench

//  Reader/executor for the script loaded into ScriptMem. Drives pc, fetches 16-bit

---
 rtl/script_pkg.sv | 34 +++
 rtl/script_executor_if.sv | 37 +++
 rtl/tick_prescaler.sv | 35 +++
 rtl/script_executor.sv | 192 +++++++++++++++++++
 tb/tb_script_executor.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/script_pkg.sv
// Package: script_pkg
// Shared definitions for the script executor: opcode values, FSM state
// encoding, the default idle command byte and the 16-bit instruction layout
// (op in [15:12], reserved nibble in [11:8], argument in [7:0]).
package script_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_SEND   = 4'h1;
  localparam logic [3:0] OP_WAIT   = 4'h2;
  localparam logic [3:0] OP_WAITFB = 4'h3;
  localparam logic [3:0] OP_JUMP   = 4'h4;
  localparam logic [3:0] OP_END    = 4'hF;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_T  = 3'd4,
    S_WAIT_FB = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // Instruction field slices; the reserved nibble is carried but never decoded.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rsvd;
    logic [7:0] arg;
  } instr_t;

endpackage

// File: rtl/script_executor_if.sv
// Interface: script_executor_if
// Bundles the ScriptMem and UART-facing signals of the script executor.
//   pc        executor -> ScriptMem   instruction address
//   script    ScriptMem -> executor   instruction at pc (1-cycle read)
//   cmd_bits  executor -> UART        command byte (io_dataIn_bits)
//   cmd_ready UART -> executor        1-cycle pulse per byte sent
//   fb_bits   UART -> executor        feedback byte (io_dataOut_bits)
//   fb_valid  UART -> executor        feedback byte valid
// master = executor side, slave = memory/UART side.
interface script_executor_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] pc;
  logic [15:0]     script;
  logic [7:0]      cmd_bits;
  logic            cmd_ready;
  logic [7:0]      fb_bits;
  logic            fb_valid;

  modport master (
    output pc,
    output cmd_bits,
    input  script,
    input  cmd_ready,
    input  fb_bits,
    input  fb_valid
  );

  modport slave (
    input  pc,
    input  cmd_bits,
    output script,
    output cmd_ready,
    output fb_bits,
    output fb_valid
  );
endinterface

// File: rtl/tick_prescaler.sv
// Module: tick_prescaler
// Divides the clock into a one-cycle tick every TICK_DIV cycles.
//   clock  in  clock
//   reset  in  asynchronous active-low reset
//   clear  in  holds the count at zero; the first tick after clear drops
//              comes exactly TICK_DIV cycles later
//   tick   out high on the last cycle of each TICK_DIV-cycle period
module tick_prescaler #(
  parameter int TICK_DIV = 15360
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Period counter: restarts on clear and after each terminal count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || (cnt_r == LAST)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = !clear && (cnt_r == LAST);

endmodule

// File: rtl/script_executor.sv
// Module: script_executor
// Fetches 16-bit instructions from ScriptMem, issues command bytes to the
// UART, and waits on timed delays or on feedback bytes.
//   clock        in   uart_clk_16
//   reset        in   asynchronous active-low reset
//   enable       in   run request; 0 aborts to IDLE
//   script_mode  in   1 while the script is being loaded; aborts to IDLE
//   bus          master modport: pc, script, cmd_bits, cmd_ready, fb_bits, fb_valid
//   running      out  1 in every state except IDLE/DONE/ERR
//   done         out  1 in DONE
//   err          out  1 in ERR
module script_executor
  import script_pkg::*;
#(
  parameter int         PC_W      = 8,
  parameter int         TICK_DIV  = 15360,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                script_mode,
  script_executor_if.master   bus,
  output logic                running,
  output logic                done,
  output logic                err
);

  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_MAX  = {PC_W{1'b1}};

  state_t          state_r, state_s, adv_state_s;
  logic [PC_W-1:0] pc_r, pc_s, adv_pc_s;
  logic [7:0]      arg_r, arg_s;
  logic [7:0]      cmd_r, cmd_s;
  logic [7:0]      wait_cnt_r, wait_cnt_s;
  logic            running_r, done_r, err_r;
  logic            abort_s, clear_s, tick_s;
  instr_t          instr_s;
  logic [3:0]      unused_rsvd_s;

  assign instr_s       = bus.script;
  assign unused_rsvd_s = instr_s.rsvd;

  // Abort wins over any completion event in the same cycle.
  assign abort_s = script_mode || !enable;

  // Stepping past the last address is an error rather than a wrap.
  assign adv_state_s = (pc_r == PC_MAX) ? S_ERR : S_FETCH;
  assign adv_pc_s    = (pc_r == PC_MAX) ? pc_r : (pc_r + PC_W'(1));

  // Prescaler runs only while waiting, so each WAIT starts a fresh period.
  assign clear_s = (state_r != S_WAIT_T) || abort_s;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Next-state and datapath updates for the executor FSM.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    arg_s      = arg_r;
    cmd_s      = cmd_r;
    wait_cnt_s = wait_cnt_r;
    if (abort_s) begin
      state_s    = S_IDLE;
      pc_s       = PC_ZERO;
      cmd_s      = IDLE_BYTE;
      wait_cnt_s = 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          pc_s    = PC_ZERO;
          state_s = S_FETCH;
        end
        S_FETCH: begin
          state_s = S_DECODE;
        end
        S_DECODE: begin
          arg_s = instr_s.arg;
          case (instr_s.op)
            OP_NOP: begin
              state_s = adv_state_s;
              pc_s    = adv_pc_s;
            end
            OP_SEND: begin
              cmd_s   = instr_s.arg;
              state_s = S_SEND;
            end
            OP_WAIT: begin
              if (instr_s.arg == 8'd0) begin
                state_s = adv_state_s;
                pc_s    = adv_pc_s;
              end else begin
                wait_cnt_s = instr_s.arg;
                state_s    = S_WAIT_T;
              end
            end
            OP_WAITFB: begin
              state_s = S_WAIT_FB;
            end
            OP_JUMP: begin
              pc_s    = PC_W'(instr_s.arg);
              state_s = S_FETCH;
            end
            OP_END: begin
              state_s = S_DONE;
            end
            default: begin
              state_s = S_ERR;
            end
          endcase
        end
        S_SEND: begin
          if (bus.cmd_ready) begin
            cmd_s   = IDLE_BYTE;
            state_s = adv_state_s;
            pc_s    = adv_pc_s;
          end else begin
            cmd_s = cmd_r;
          end
        end
        S_WAIT_T: begin
          if (tick_s) begin
            if (wait_cnt_r == 8'd1) begin
              wait_cnt_s = 8'd0;
              state_s    = adv_state_s;
              pc_s       = adv_pc_s;
            end else begin
              wait_cnt_s = wait_cnt_r - 8'd1;
            end
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
        end
        S_WAIT_FB: begin
          if (bus.fb_valid && (bus.fb_bits == arg_r)) begin
            state_s = adv_state_s;
            pc_s    = adv_pc_s;
          end else begin
            state_s = S_WAIT_FB;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        S_ERR: begin
          state_s = S_ERR;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      pc_r       <= PC_ZERO;
      arg_r      <= 8'd0;
      cmd_r      <= IDLE_BYTE;
      wait_cnt_r <= 8'd0;
      running_r  <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      arg_r      <= arg_s;
      cmd_r      <= cmd_s;
      wait_cnt_r <= wait_cnt_s;
      running_r  <= (state_s != S_IDLE) && (state_s != S_DONE) && (state_s != S_ERR);
      done_r     <= (state_s == S_DONE);
      err_r      <= (state_s == S_ERR);
    end
  end

  assign bus.pc       = pc_r;
  assign bus.cmd_bits = cmd_r;
  assign running      = running_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_script_executor.sv
// Testbench for script_executor: directed scenarios followed by random
// straight-line scripts compared against a small instruction interpreter.
module tb_script_executor;

  localparam int PC_W     = 8;
  localparam int TICK_DIV = 4;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic script_mode;
  logic running;
  logic done;
  logic err;

  logic [15:0] mem [0:255];
  logic [7:0]  fb_set [0:3];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  script_executor_if #(.PC_W(PC_W)) bus ();

  script_executor #(
    .PC_W      (PC_W),
    .TICK_DIV  (TICK_DIV),
    .IDLE_BYTE (8'h00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .script_mode (script_mode),
    .bus         (bus),
    .running     (running),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  // ScriptMem model: registered read of the current pc.
  always @(posedge clock) bus.script <= mem[bus.pc];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic wait_end(input int budget);
    int used;
    used = 0;
    while (!(done || err) && used < budget) begin
      @(negedge clock);
      used++;
    end
  endtask

  // Reference interpreter: walks the script and lists the bytes it sends.
  task automatic model_run(output int final_pc, output logic final_err);
    int pc;
    int steps;
    logic [3:0] op;
    logic [7:0] arg;
    pc = 0;
    steps = 0;
    final_err = 1'b0;
    exp_q.delete();
    while (steps < 1000) begin
      op = mem[pc][15:12];
      arg = mem[pc][7:0];
      steps++;
      if (op == 4'h1) begin
        exp_q.push_back(arg);
        pc++;
      end else if (op == 4'h4) begin
        pc = int'(arg);
      end else if (op == 4'hF) begin
        break;
      end else if (op == 4'h0 || op == 4'h2 || op == 4'h3) begin
        pc++;
      end else begin
        final_err = 1'b1;
        break;
      end
      if (pc > 255) begin
        pc = 255;
        final_err = 1'b1;
        break;
      end
    end
    final_pc = pc;
  endtask

  initial begin
    int n;
    int len;
    int idx;
    int kind;
    int exp_pc;
    logic exp_err;
    logic [3:0] rsvd;

    fb_set[0] = 8'h11; fb_set[1] = 8'h22; fb_set[2] = 8'h33; fb_set[3] = 8'h44;
    reset = 1'b0; enable = 1'b0; script_mode = 1'b0;
    bus.cmd_ready = 1'b0; bus.fb_valid = 1'b0; bus.fb_bits = 8'h00;
    fill(16'h7000);
    cycles(2);
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_cmd", 32'(bus.cmd_bits), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b1;

    // SEND 41, WAIT 3, END
    mem[0] = 16'h1041; mem[1] = 16'h2003; mem[2] = 16'hF000;
    enable = 1'b1;
    cycles(3);
    check("send_cmd", 32'(bus.cmd_bits), 32'h41);
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("send_hold", 32'(bus.cmd_bits), 32'h41);
    end
    bus.cmd_ready = 1'b1;
    cycles(1);
    bus.cmd_ready = 1'b0;
    check("send_release_cmd", 32'(bus.cmd_bits), 32'h0);
    check("send_release_pc", 32'(bus.pc), 32'h1);
    n = 0;
    while (bus.pc == 8'd1 && n < 100) begin
      cycles(1);
      n++;
    end
    check("wait_cycles", 32'(n), 32'(2 + 3 * TICK_DIV));
    wait_end(20);
    check("t1_done", 32'(done), 32'h1);
    check("t1_pc", 32'(bus.pc), 32'h2);
    check("t1_running", 32'(running), 32'h0);

    // WAITFB A5, END
    enable = 1'b0;
    cycles(1);
    check("abort_done_clear", 32'(done), 32'h0);
    fill(16'h7000);
    mem[0] = 16'h30A5; mem[1] = 16'hF000;
    enable = 1'b1;
    cycles(3);
    bus.fb_bits = 8'h3C; bus.fb_valid = 1'b1;
    cycles(1);
    bus.fb_valid = 1'b0;
    cycles(2);
    check("fb_nomatch_pc", 32'(bus.pc), 32'h0);
    check("fb_nomatch_running", 32'(running), 32'h1);
    bus.fb_bits = 8'hA5; bus.fb_valid = 1'b1;
    cycles(1);
    bus.fb_valid = 1'b0;
    check("fb_match_pc", 32'(bus.pc), 32'h1);
    wait_end(10);
    check("t2_done", 32'(done), 32'h1);

    // NOP / JUMP 0 loop, then abort
    enable = 1'b0;
    cycles(1);
    fill(16'h7000);
    mem[0] = 16'h0000; mem[1] = 16'h4000;
    enable = 1'b1;
    cycles(20);
    check("loop_running", 32'(running), 32'h1);
    enable = 1'b0;
    cycles(1);
    check("abort_running", 32'(running), 32'h0);
    check("abort_pc", 32'(bus.pc), 32'h0);
    check("abort_cmd", 32'(bus.cmd_bits), 32'h0);

    // illegal opcode, then restart from pc 0
    mem[0] = 16'h7000;
    enable = 1'b1;
    wait_end(10);
    check("bad_op_err", 32'(err), 32'h1);
    check("bad_op_running", 32'(running), 32'h0);
    enable = 1'b0;
    cycles(1);
    check("err_clear", 32'(err), 32'h0);
    mem[0] = 16'hF000;
    enable = 1'b1;
    wait_end(10);
    check("restart_done", 32'(done), 32'h1);
    check("restart_pc", 32'(bus.pc), 32'h0);

    // script_mode mid-SEND with simultaneous cmd_ready
    enable = 1'b0;
    cycles(1);
    mem[0] = 16'h1055; mem[1] = 16'hF000;
    enable = 1'b1;
    cycles(3);
    check("sm_send_cmd", 32'(bus.cmd_bits), 32'h55);
    script_mode = 1'b1; bus.cmd_ready = 1'b1;
    cycles(1);
    bus.cmd_ready = 1'b0;
    check("sm_cmd", 32'(bus.cmd_bits), 32'h0);
    check("sm_pc", 32'(bus.pc), 32'h0);
    check("sm_running", 32'(running), 32'h0);
    enable = 1'b0;
    cycles(1);
    script_mode = 1'b0;

    // 256 NOPs without END
    fill(16'h0000);
    enable = 1'b1;
    wait_end(1000);
    check("pc_overflow_err", 32'(err), 32'h1);
    check("pc_overflow_pc", 32'(bus.pc), 32'hFF);
    check("pc_overflow_done", 32'(done), 32'h0);
    enable = 1'b0;
    cycles(1);

    // reset in the middle of a WAIT
    fill(16'h7000);
    mem[0] = 16'h2010;
    enable = 1'b1;
    cycles(10);
    check("midwait_running", 32'(running), 32'h1);
    reset = 1'b0;
    #1;
    check("midwait_rst_pc", 32'(bus.pc), 32'h0);
    check("midwait_rst_cmd", 32'(bus.cmd_bits), 32'h0);
    check("midwait_rst_running", 32'(running), 32'h0);
    check("midwait_rst_err", 32'(err), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (bus.pc == 8'd0 && n < 200) begin
      cycles(1);
      n++;
    end
    check("rerun_wait_cycles", 32'(n), 32'(3 + 16 * TICK_DIV));
    enable = 1'b0;
    cycles(1);

    // random scripts against the interpreter
    for (int iter = 0; iter < 8; iter++) begin
      fill(16'h7000);
      len = $urandom_range(3, 9);
      idx = 0;
      while (idx < len) begin
        kind = $urandom_range(0, 4);
        rsvd = 4'($urandom);
        case (kind)
          0: mem[idx] = {4'h0, rsvd, 8'($urandom)};
          1: mem[idx] = {4'h1, rsvd, 8'($urandom_range(1, 255))};
          2: mem[idx] = {4'h2, rsvd, 8'($urandom_range(0, 3))};
          3: mem[idx] = {4'h3, rsvd, fb_set[$urandom_range(0, 3)]};
          default: begin
            if (idx + 2 <= len) begin
              mem[idx] = {4'h4, rsvd, 8'(idx + 2)};
              idx++;
              mem[idx] = {4'h7, rsvd, 8'($urandom)};
            end else begin
              mem[idx] = {4'h0, rsvd, 8'h00};
            end
          end
        endcase
        idx++;
      end
      mem[len] = {4'hF, 4'($urandom), 8'($urandom)};
      model_run(exp_pc, exp_err);
      got_q.delete();
      enable = 1'b1;
      n = 0;
      while (!(done || err) && n < 3000) begin
        @(negedge clock);
        n++;
        if (bus.cmd_bits != 8'h00 && $urandom_range(0, 2) == 0) begin
          bus.cmd_ready = 1'b1;
          got_q.push_back(bus.cmd_bits);
        end else begin
          bus.cmd_ready = (bus.cmd_bits == 8'h00) && ($urandom_range(0, 7) == 0);
        end
        bus.fb_valid = 1'($urandom_range(0, 1));
        bus.fb_bits  = fb_set[$urandom_range(0, 3)];
      end
      bus.cmd_ready = 1'b0;
      bus.fb_valid = 1'b0;
      check("rnd_done", 32'(done), 32'(!exp_err));
      check("rnd_err", 32'(err), 32'(exp_err));
      check("rnd_pc", 32'(bus.pc), 32'(exp_pc));
      check("rnd_send_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        check("rnd_send_byte", 32'(got_q[k]), 32'(exp_q[k]));
      end
      enable = 1'b0;
      cycles(2);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
